// File: rtl/exam_pkg.sv
// Shared default widths and request/response record types for the exam initiator.
package exam_pkg;

    localparam int unsigned ExamW   = 3;
    localparam int unsigned ExamLat = 2;
    localparam int unsigned ExamTw  = 4;

    typedef struct packed {
        logic [ExamW-1:0] a, b, c, d, e, f;
        logic [ExamW-1:0] op1, op2, op3;
    } req_t;

    typedef struct packed {
        logic [ExamW-1:0]  ra, rb, rc;
        logic [ExamTw-1:0] tag;
    } rsp_t;

endpackage

// File: rtl/exam_master_if.sv
// Request, response and exam-bus signals of exam_master; master is the initiator's view.
interface exam_master_if
    import exam_pkg::*;
#(
    parameter int unsigned W  = ExamW,
    parameter int unsigned TW = ExamTw
) ();

    logic          req_valid, req_ready;
    logic [W-1:0]  req_a, req_b, req_c, req_d, req_e, req_f;
    logic [W-1:0]  req_op1, req_op2, req_op3;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_ra, rsp_rb, rsp_rc;
    logic [TW-1:0] rsp_tag;
    logic [W-1:0]  bus_da, bus_db, bus_dc, bus_dd, bus_de, bus_df;
    logic [W-1:0]  bus_op1, bus_op2, bus_op3;
    logic [W-1:0]  bus_ra, bus_rb, bus_rc;

    modport master (
        input  req_valid, req_a, req_b, req_c, req_d, req_e, req_f, req_op1, req_op2, req_op3,
        output req_ready,
        output rsp_valid, rsp_ra, rsp_rb, rsp_rc, rsp_tag,
        input  rsp_ready,
        output bus_da, bus_db, bus_dc, bus_dd, bus_de, bus_df, bus_op1, bus_op2, bus_op3,
        input  bus_ra, bus_rb, bus_rc
    );

    modport slave (
        output req_valid, req_a, req_b, req_c, req_d, req_e, req_f, req_op1, req_op2, req_op3,
        input  req_ready,
        input  rsp_valid, rsp_ra, rsp_rb, rsp_rc, rsp_tag,
        output rsp_ready,
        input  bus_da, bus_db, bus_dc, bus_dd, bus_de, bus_df, bus_op1, bus_op2, bus_op3,
        output bus_ra, bus_rb, bus_rc
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read; a push when full or pop when empty is
// ignored.
module sync_fifo #(
    parameter type          T     = logic,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  T                din_i,
    input  logic            pop_i,
    output T                dout_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
        return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: empty_o gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/exam_master.sv
// Initiator for exam: queues tagged requests, issues under a credit limit, tracks the fixed
// pipeline latency and captures results into an in-order response FIFO.
module exam_master
    import exam_pkg::*;
#(
    parameter int unsigned W     = ExamW,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = ExamLat,
    parameter int unsigned TW    = ExamTw
) (
    input  logic          clk,
    input  logic          rst,
    exam_master_if.master io
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned FlyW = $clog2(LAT + 2);

    // Record types come from exam_pkg, so lane and tag widths cannot be overridden here.
    if (W != ExamW || TW != ExamTw) begin : g_width_mismatch
        $error("exam_master: W and TW must match exam_pkg");
    end

    typedef struct packed {
        req_t          req;
        logic [TW-1:0] tag;
    } req_ent_t;

    req_ent_t        req_din, req_head;
    logic            req_push, req_full, req_empty;
    logic [CntW-1:0] req_count;
    rsp_t            rsp_din, rsp_head;
    logic            rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [CntW-1:0] rsp_count;
    logic            issue;
    logic [FlyW-1:0] inflight;
    logic [31:0]     credits_used;

    logic [TW-1:0]   acc_cnt_q, acc_cnt_d;
    req_t            bus_q, bus_d;
    logic [LAT:0]    trk_vld_q, trk_vld_d;
    logic [TW-1:0]   trk_tag_q [LAT+1];
    logic [TW-1:0]   trk_tag_d [LAT+1];

    sync_fifo #(
        .T     (req_ent_t),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (req_push),
        .din_i   (req_din),
        .pop_i   (issue),
        .dout_o  (req_head),
        .full_o  (req_full),
        .empty_o (req_empty),
        .count_o (req_count)
    );

    sync_fifo #(
        .T     (rsp_t),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rsp_push),
        .din_i   (rsp_din),
        .pop_i   (rsp_pop),
        .dout_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    always_comb begin
        req_push    = io.req_valid && !req_full;
        req_din.req = '{a: io.req_a, b: io.req_b, c: io.req_c, d: io.req_d, e: io.req_e,
                        f: io.req_f, op1: io.req_op1, op2: io.req_op2, op3: io.req_op3};
        req_din.tag = acc_cnt_q;

        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + FlyW'(trk_vld_q[i]);
        end
        // Every issued slot holds a response-FIFO credit until it is popped.
        credits_used = 32'(inflight) + 32'(rsp_count);
        issue        = !req_empty && (credits_used < DEPTH);

        rsp_push = trk_vld_q[LAT];
        rsp_din  = '{ra: io.bus_ra, rb: io.bus_rb, rc: io.bus_rc, tag: trk_tag_q[LAT]};
        rsp_pop  = !rsp_empty && io.rsp_ready;
    end

    always_comb begin
        acc_cnt_d    = acc_cnt_q + TW'(req_push);
        bus_d        = issue ? req_head.req : '0;
        trk_vld_d[0] = issue;
        trk_tag_d[0] = req_head.tag;
        for (int i = 1; i <= LAT; i++) begin
            trk_vld_d[i] = trk_vld_q[i-1];
            trk_tag_d[i] = trk_tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= '0;
            bus_q     <= '0;
            trk_vld_q <= '0;
            for (int i = 0; i <= LAT; i++) begin
                trk_tag_q[i] <= '0;
            end
        end else begin
            acc_cnt_q <= acc_cnt_d;
            bus_q     <= bus_d;
            trk_vld_q <= trk_vld_d;
            for (int i = 0; i <= LAT; i++) begin
                trk_tag_q[i] <= trk_tag_d[i];
            end
        end
    end

    assign io.req_ready = !req_full;
    assign io.rsp_valid = !rsp_empty;
    assign io.rsp_ra    = rsp_empty ? '0 : rsp_head.ra;
    assign io.rsp_rb    = rsp_empty ? '0 : rsp_head.rb;
    assign io.rsp_rc    = rsp_empty ? '0 : rsp_head.rc;
    assign io.rsp_tag   = rsp_empty ? '0 : rsp_head.tag;

    assign io.bus_da  = bus_q.a;
    assign io.bus_db  = bus_q.b;
    assign io.bus_dc  = bus_q.c;
    assign io.bus_dd  = bus_q.d;
    assign io.bus_de  = bus_q.e;
    assign io.bus_df  = bus_q.f;
    assign io.bus_op1 = bus_q.op1;
    assign io.bus_op2 = bus_q.op2;
    assign io.bus_op3 = bus_q.op3;

    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_push && rsp_full));
    a_req_count_bound: assert property (@(posedge clk) disable iff (rst) req_count <= CntW'(DEPTH));

endmodule

// File: tb/tb_exam_master.sv
// Randomized bench for exam_master against a queue-based transaction model and a 2-stage exam.
module tb_exam_master;
    import exam_pkg::*;

    localparam int unsigned W     = ExamW;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = ExamLat;
    localparam int unsigned TW    = ExamTw;

    typedef struct packed {
        req_t          r;
        logic [TW-1:0] tag;
    } ent_t;

    typedef struct packed {
        ent_t        e;
        int unsigned due;
    } fly_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exam_master_if #(.W(W), .TW(TW)) io ();

    exam_master #(
        .W     (W),
        .DEPTH (DEPTH),
        .LAT   (LAT),
        .TW    (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.master)
    );

    // exam stand-in: input registers, then result registers.
    req_t ex_in_q;
    always @(posedge clk) begin
        ex_in_q   <= '{a: io.bus_da, b: io.bus_db, c: io.bus_dc, d: io.bus_dd, e: io.bus_de,
                       f: io.bus_df, op1: io.bus_op1, op2: io.bus_op2, op3: io.bus_op3};
        io.bus_ra <= ex_in_q.a + ex_in_q.b + ex_in_q.op1;
        io.bus_rb <= ex_in_q.c + ex_in_q.d + ex_in_q.op2;
        io.bus_rc <= ex_in_q.e + ex_in_q.f + ex_in_q.op3;
    end

    int unsigned   n_chk = 0;
    int unsigned   n_err = 0;
    ent_t          m_req[$];
    fly_t          m_fly[$];
    rsp_t          m_rsp[$];
    req_t          m_bus = '0;
    int unsigned   m_acc = 0;
    int unsigned   m_edge = 0;
    logic [TW-1:0] got_tags[$];
    int unsigned   n_acc = 0;
    int unsigned   n_iss = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic rsp_t result_of(input ent_t x);
        rsp_t o;
        o.ra  = x.r.a + x.r.b + x.r.op1;
        o.rb  = x.r.c + x.r.d + x.r.op2;
        o.rc  = x.r.e + x.r.f + x.r.op3;
        o.tag = x.tag;
        return o;
    endfunction

    function automatic req_t rnd_req(input bit nz_op1);
        logic [31:0] x;
        req_t        r;
        x = $urandom;
        r = req_t'(x[$bits(req_t)-1:0]);
        if (nz_op1 && r.op1 == '0) r.op1 = 3'd1;
        return r;
    endfunction

    function automatic int tag_at(input int i);
        if (i < got_tags.size()) return int'(got_tags[i]);
        return -1;
    endfunction

    // Transaction-level view of one clock edge, evaluated from pre-edge state.
    task automatic model_edge(input bit v, input req_t r, input bit rr, input bit rs);
        bit acc, pop, iss;
        ent_t e;
        m_edge++;
        if (rs) begin
            m_req.delete();
            m_fly.delete();
            m_rsp.delete();
            m_bus = '0;
            m_acc = 0;
            return;
        end
        acc = v && (m_req.size() < DEPTH);
        pop = (m_rsp.size() > 0) && rr;
        iss = (m_req.size() > 0) && ((m_fly.size() + m_rsp.size()) < DEPTH);
        if (pop) void'(m_rsp.pop_front());
        if (m_fly.size() > 0 && m_fly[0].due == m_edge) begin
            m_rsp.push_back(result_of(m_fly[0].e));
            void'(m_fly.pop_front());
        end
        if (iss) begin
            e = m_req.pop_front();
            m_bus = e.r;
            m_fly.push_back('{e: e, due: m_edge + LAT + 1});
        end else begin
            m_bus = '0;
        end
        if (acc) begin
            m_req.push_back('{r: r, tag: m_acc[TW-1:0]});
            m_acc++;
        end
    endtask

    task automatic compare();
        rsp_t f;
        f = (m_rsp.size() > 0) ? m_rsp[0] : '0;
        check("handshake", 64'({io.req_ready, io.rsp_valid, io.rsp_ra, io.rsp_rb, io.rsp_rc,
                                io.rsp_tag}),
              64'({m_req.size() < DEPTH, m_rsp.size() > 0, f}));
        check("bus", 64'({io.bus_da, io.bus_db, io.bus_dc, io.bus_dd, io.bus_de, io.bus_df,
                          io.bus_op1, io.bus_op2, io.bus_op3}), 64'(m_bus));
    endtask

    task automatic cycle(input bit v, input req_t r, input bit rr, input bit rs);
        rst          = rs;
        io.req_valid = v;
        io.req_a     = r.a;
        io.req_b     = r.b;
        io.req_c     = r.c;
        io.req_d     = r.d;
        io.req_e     = r.e;
        io.req_f     = r.f;
        io.req_op1   = r.op1;
        io.req_op2   = r.op2;
        io.req_op3   = r.op3;
        io.rsp_ready = rr;
        if (!rs && v && io.req_ready === 1'b1) n_acc++;
        if (!rs && rr && io.rsp_valid === 1'b1) got_tags.push_back(io.rsp_tag);
        @(posedge clk);
        model_edge(v, r, rr, rs);
        @(negedge clk);
        compare();
        if (io.bus_op1 !== '0) n_iss++;
    endtask

    task automatic drain(input int unsigned max_cyc);
        int unsigned k = 0;
        while ((m_req.size() + m_fly.size() + m_rsp.size()) != 0 && k < max_cyc) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        check("drain_idle", 64'({io.rsp_valid, io.req_ready}), 64'(2'b01));
    endtask

    initial begin
        req_t        r0;
        int unsigned k;

        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("reset_state", 64'({io.req_ready, io.rsp_valid, io.rsp_tag, io.bus_op1}),
              64'({1'b1, 1'b0, 4'd0, 3'd0}));

        // Single request, latency and exam arithmetic.
        r0 = '{a: 3'd1, b: 3'd2, c: 3'd0, d: 3'd4, e: 3'd7, f: 3'd7,
               op1: 3'd3, op2: 3'd1, op3: 3'd0};
        cycle(1'b1, r0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("single_issue", 64'({io.bus_da, io.bus_db, io.bus_op1}),
              64'({3'd1, 3'd2, 3'd3}));
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("single_bus_idle", 64'(io.bus_op1), 64'(0));
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("single_not_yet", 64'(io.rsp_valid), 64'(0));
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("single_rsp", 64'({io.rsp_valid, io.rsp_ra, io.rsp_rb, io.rsp_rc, io.rsp_tag}),
              64'({1'b1, 3'd6, 3'd5, 3'd6, 4'd0}));
        drain(20);

        // Back-to-back with a ready consumer.
        n_acc = 0;
        got_tags.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, rnd_req(1'b0), 1'b1, 1'b0);
        check("b2b_accepts", 64'(n_acc), 64'(8));
        drain(40);
        check("b2b_rsp_count", 64'(got_tags.size()), 64'(8));
        for (int i = 0; i < 8; i++) check("b2b_tag", 64'(tag_at(i)), 64'(i + 1));

        // Credit stall with the consumer blocked.
        n_acc = 0;
        n_iss = 0;
        got_tags.delete();
        for (int i = 0; i < 14; i++) cycle(1'b1, rnd_req(1'b1), 1'b0, 1'b0);
        check("stall_issues", 64'(n_iss), 64'(4));
        check("stall_accepts", 64'(n_acc), 64'(8));
        check("stall_ready", 64'(io.req_ready), 64'(0));
        drain(60);
        check("stall_rsp_count", 64'(got_tags.size()), 64'(8));
        for (int i = 0; i < 8; i++) check("stall_tag", 64'(tag_at(i)), 64'((9 + i) % 16));

        // Reset with two in flight and one queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_req(1'b1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("rst_mid", 64'({io.rsp_valid, io.req_ready, io.bus_da, io.bus_op1, io.bus_op3}),
              64'({1'b0, 1'b1, 9'd0}));

        // Tag wrap; the first request after reset must carry tag 0.
        n_acc = 0;
        k = 0;
        got_tags.delete();
        while (n_acc < 20 && k < 200) begin
            cycle(1'b1, rnd_req(1'b0), 1'b1, 1'b0);
            k++;
        end
        drain(60);
        check("wrap_count", 64'(got_tags.size()), 64'(20));
        check("rst_tag0", 64'(tag_at(0)), 64'(0));
        check("wrap_tag15", 64'(tag_at(15)), 64'(15));
        check("wrap_tag17", 64'(tag_at(16)), 64'(0));

        // Random traffic with occasional resets.
        for (int i = 0; i < 1000; i++) begin
            cycle(($urandom % 4) != 0, rnd_req(1'b0), ($urandom % 3) != 0,
                  ($urandom % 250) == 0);
        end
        drain(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
